// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: buffers ALU (A) and LSU (M) results in two FIFOs and retires one per
// cycle into the registered regfile write port; also answers pending-write hazard queries.
module wb_write_arbiter #(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              m_valid,
   output logic              m_ready,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_data,
   output logic [ADDR_W-1:0] w_addr,
   output logic              write_request,
   output logic [DATA_W-1:0] w_data,
   input  logic [ADDR_W-1:0] q_addr,
   output logic              q_pending
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

   // Index 0 is the ALU FIFO, index 1 the LSU FIFO.
   logic [ADDR_W-1:0] r_addr_mem [2][FIFO_DEPTH];
   logic [DATA_W-1:0] r_data_mem [2][FIFO_DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr [2];
   logic [PTR_W-1:0]  r_wr_ptr [2];
   logic [CNT_W-1:0]  r_cnt [2];
   logic [STV_W-1:0]  r_starve;

   logic [1:0]        w_in_valid;
   logic [ADDR_W-1:0] w_in_addr [2];
   logic [DATA_W-1:0] w_in_data [2];
   logic [1:0]        w_ready;
   logic [1:0]        w_nempty;
   logic [1:0]        w_push;
   logic [1:0]        w_pop;
   logic              w_hit;

   // A slot holds a live entry when its distance from the read pointer is below the count.
   function automatic logic slot_live(input logic [CNT_W-1:0] cnt,
                                      input logic [PTR_W-1:0] rd,
                                      input int               slot);
      logic [PTR_W-1:0] off;
      off = PTR_W'(slot) - rd;
      return ({1'b0, off} < cnt);
   endfunction

   assign w_in_valid   = {m_valid, a_valid};
   assign w_in_addr[0] = a_addr;
   assign w_in_addr[1] = m_addr;
   assign w_in_data[0] = a_data;
   assign w_in_data[1] = m_data;
   assign a_ready      = w_ready[0];
   assign m_ready      = w_ready[1];

   // Per-FIFO ready/push/occupancy; x0 results are handshaken but never enqueued.
   always_comb begin
      w_ready  = 2'b00;
      w_nempty = 2'b00;
      w_push   = 2'b00;
      for (int i = 0; i < 2; i++) begin
         w_ready[i]  = rst && (r_cnt[i] < DEPTH_C);
         w_nempty[i] = (r_cnt[i] != {CNT_W{1'b0}});
         w_push[i]   = w_in_valid[i] && w_ready[i] && (w_in_addr[i] != {ADDR_W{1'b0}});
      end
   end

   // Arbitration: M has priority unless A has already lost STARVE_LIMIT times in a row.
   always_comb begin
      w_pop = 2'b00;
      if (w_nempty[0] && w_nempty[1]) begin
         if (r_starve == LIMIT_C) w_pop = 2'b01;
         else                     w_pop = 2'b10;
      end else if (w_nempty[1]) begin
         w_pop = 2'b10;
      end else if (w_nempty[0]) begin
         w_pop = 2'b01;
      end else begin
         w_pop = 2'b00;
      end
   end

   // Hazard query over every live FIFO slot; the output register is deliberately excluded.
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < FIFO_DEPTH; j++) begin
            w_hit = w_hit | (slot_live(r_cnt[i], r_rd_ptr[i], j) && (r_addr_mem[i][j] == q_addr));
         end
      end
      q_pending = rst && (q_addr != {ADDR_W{1'b0}}) && w_hit;
   end

   // FIFO storage; contents need no reset because occupancy is tracked by the counters.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (w_push[i]) begin
            r_addr_mem[i][r_wr_ptr[i]] <= w_in_addr[i];
            r_data_mem[i][r_wr_ptr[i]] <= w_in_data[i];
         end
      end
   end

   // FIFO pointers/counts, starvation counter and the registered write port.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            r_rd_ptr[i] <= {PTR_W{1'b0}};
            r_wr_ptr[i] <= {PTR_W{1'b0}};
            r_cnt[i]    <= {CNT_W{1'b0}};
         end
         r_starve      <= {STV_W{1'b0}};
         write_request <= 1'b0;
         w_addr        <= {ADDR_W{1'b0}};
         w_data        <= {DATA_W{1'b0}};
      end else begin
         for (int i = 0; i < 2; i++) begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
            if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
            if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
         end
         if (w_pop[0] || !w_nempty[0])          r_starve <= {STV_W{1'b0}};
         else if (w_pop[1] && r_starve != LIMIT_C) r_starve <= r_starve + STV_W'(1);
         else                                   r_starve <= r_starve;
         if (w_pop[0]) begin
            write_request <= 1'b1;
            w_addr        <= r_addr_mem[0][r_rd_ptr[0]];
            w_data        <= r_data_mem[0][r_rd_ptr[0]];
         end else if (w_pop[1]) begin
            write_request <= 1'b1;
            w_addr        <= r_addr_mem[1][r_rd_ptr[1]];
            w_data        <= r_data_mem[1][r_rd_ptr[1]];
         end else begin
            write_request <= 1'b0;
         end
      end
   end
endmodule
